sprite_loader: RTL



---
 rtl/sprite_loader_if.sv | 61 ++++++
 rtl/sprite_loader.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_loader_if.sv
// Byte-stream handshake plus the image/palette BRAM write ports of sprite_loader.
interface sprite_loader_if #(
  parameter int unsigned ImgAw = 16
) ();

  // Stream side
  logic [7:0]       data_in;
  logic             valid_in;
  logic             ready_out;
  logic             abort_in;

  // Image RAM write port
  logic [ImgAw-1:0] img_addr_out;
  logic [7:0]       img_data_out;
  logic             img_we_out;

  // Palette RAM write port
  logic [7:0]       pal_addr_out;
  logic [23:0]      pal_data_out;
  logic             pal_we_out;

  // Status
  logic             busy_out;
  logic             done_out;
  logic             err_out;

  // Byte source and RAM/status observer
  modport master (
    output data_in,
    output valid_in,
    output abort_in,
    input  ready_out,
    input  img_addr_out,
    input  img_data_out,
    input  img_we_out,
    input  pal_addr_out,
    input  pal_data_out,
    input  pal_we_out,
    input  busy_out,
    input  done_out,
    input  err_out
  );

  // The loader itself
  modport slave (
    input  data_in,
    input  valid_in,
    input  abort_in,
    output ready_out,
    output img_addr_out,
    output img_data_out,
    output img_we_out,
    output pal_addr_out,
    output pal_data_out,
    output pal_we_out,
    output busy_out,
    output done_out,
    output err_out
  );

endinterface

// File: rtl/sprite_loader.sv
// Stream-to-BRAM writer: parses a command byte, then fills the palette RAM
// ({R,G,B} per three bytes) or the image RAM (one palette index per byte).
module sprite_loader #(
  parameter int unsigned WIDTH     = 256,
  parameter int unsigned HEIGHT    = 256,
  parameter int unsigned PAL_DEPTH = 256
) (
  input logic            pixel_clk_in,
  input logic            rst_n_in,
  sprite_loader_if.slave bus
);

  localparam int unsigned ImgSize = WIDTH * HEIGHT;
  localparam int unsigned ImgAw   = (ImgSize > 1) ? $clog2(ImgSize) : 1;

  localparam logic [ImgAw-1:0] ImgLast = ImgAw'(ImgSize - 1);
  localparam logic [7:0]       PalLast = 8'(PAL_DEPTH - 1);
  localparam logic [7:0]       CmdPal  = 8'hA5;
  localparam logic [7:0]       CmdImg  = 8'h5A;

  typedef enum logic [2:0] {
    StIdle,
    StPalR,
    StPalG,
    StPalB,
    StImg,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Registered outputs and their next values
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             pal_we_q, pal_we_d;
  logic [7:0]       pal_addr_q, pal_addr_d;
  logic [23:0]      pal_data_q, pal_data_d;
  logic             img_we_q, img_we_d;
  logic [ImgAw-1:0] img_addr_q, img_addr_d;
  logic [7:0]       img_data_q, img_data_d;

  // Datapath state
  logic [7:0]       r_q, r_d;
  logic [7:0]       g_q, g_d;
  logic [7:0]       pal_cnt_q, pal_cnt_d;
  logic [ImgAw-1:0] img_cnt_q, img_cnt_d;

  logic accept;
  logic pal_last;
  logic img_last;
  logic cmd_ok;

  assign accept   = bus.valid_in && ready_q;
  assign pal_last = (pal_cnt_q == PalLast);
  assign img_last = (img_cnt_q == ImgLast);
  // A command byte only counts when no abort discards it in the same cycle
  assign cmd_ok   = accept && (state_q == StIdle) && !bus.abort_in;

  // State register
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; abort overrides everything, including a final byte
  always_comb begin
    state_d = state_q;
    if (bus.abort_in) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (bus.data_in == CmdPal) begin
              state_d = StPalR;
            end else if (bus.data_in == CmdImg) begin
              state_d = StImg;
            end
          end
        end
        StPalR: if (accept) state_d = StPalG;
        StPalG: if (accept) state_d = StPalB;
        StPalB: if (accept) state_d = pal_last ? StDone : StPalR;
        StImg:  if (accept && img_last) state_d = StDone;
        StDone: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output and datapath next values
  always_comb begin
    ready_d    = (state_d != StDone);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    err_d      = cmd_ok && (bus.data_in != CmdPal) && (bus.data_in != CmdImg);

    pal_we_d   = 1'b0;
    pal_addr_d = pal_addr_q;
    pal_data_d = pal_data_q;
    img_we_d   = 1'b0;
    img_addr_d = img_addr_q;
    img_data_d = img_data_q;
    r_d        = r_q;
    g_d        = g_q;
    pal_cnt_d  = pal_cnt_q;
    img_cnt_d  = img_cnt_q;

    if (cmd_ok && (bus.data_in == CmdPal)) begin
      pal_cnt_d = '0;
    end
    if (cmd_ok && (bus.data_in == CmdImg)) begin
      img_cnt_d = '0;
    end

    if (accept && !bus.abort_in && (state_q == StPalR)) begin
      r_d = bus.data_in;
    end
    if (accept && !bus.abort_in && (state_q == StPalG)) begin
      g_d = bus.data_in;
    end

    // The byte that finishes a load is written even when abort arrives with it
    if (accept && (state_q == StPalB) && (!bus.abort_in || pal_last)) begin
      pal_we_d   = 1'b1;
      pal_addr_d = pal_cnt_q;
      pal_data_d = {r_q, g_q, bus.data_in};
      if (!pal_last) begin
        pal_cnt_d = pal_cnt_q + 8'd1;
      end
    end

    if (accept && (state_q == StImg) && (!bus.abort_in || img_last)) begin
      img_we_d   = 1'b1;
      img_addr_d = img_cnt_q;
      img_data_d = bus.data_in;
      if (!img_last) begin
        img_cnt_d = img_cnt_q + 1'b1;
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pal_we_q   <= 1'b0;
      pal_addr_q <= '0;
      pal_data_q <= '0;
      img_we_q   <= 1'b0;
      img_addr_q <= '0;
      img_data_q <= '0;
      r_q        <= '0;
      g_q        <= '0;
      pal_cnt_q  <= '0;
      img_cnt_q  <= '0;
    end else begin
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pal_we_q   <= pal_we_d;
      pal_addr_q <= pal_addr_d;
      pal_data_q <= pal_data_d;
      img_we_q   <= img_we_d;
      img_addr_q <= img_addr_d;
      img_data_q <= img_data_d;
      r_q        <= r_d;
      g_q        <= g_d;
      pal_cnt_q  <= pal_cnt_d;
      img_cnt_q  <= img_cnt_d;
    end
  end

  assign bus.ready_out    = ready_q;
  assign bus.busy_out     = busy_q;
  assign bus.done_out     = done_q;
  assign bus.err_out      = err_q;
  assign bus.pal_we_out   = pal_we_q;
  assign bus.pal_addr_out = pal_addr_q;
  assign bus.pal_data_out = pal_data_q;
  assign bus.img_we_out   = img_we_q;
  assign bus.img_addr_out = img_addr_q;
  assign bus.img_data_out = img_data_q;

endmodule
